// File: rtl/bnn_pkg.sv
// Shared definitions for the binarised-neuron datapath.
//   pc_w(n)    : width of a popcount over n bits (holds 0..n)
//   DEF_ACC_W  : default accumulator / threshold width
//   sat_add()  : unsigned add clamped to 2^w-1 (never wraps)
//   sat_ovf()  : flags that sat_add() had to clamp
// The saturating helpers work on a fixed SAT_W-bit container so one
// function serves every accumulator width up to SAT_W.
package bnn_pkg;

  localparam int DEF_ACC_W = 16;
  localparam int SAT_W     = 32;

  function automatic int pc_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Largest value representable in w bits, in a (SAT_W+1)-bit container.
  function automatic logic [SAT_W:0] sat_max(input int unsigned w);
    return ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
  endfunction

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] full;
    logic [SAT_W:0] lim;
    full = {1'b0, a} + {1'b0, b};
    lim  = sat_max(w);
    if (full > lim) begin
      return lim[SAT_W-1:0];
    end else begin
      return full[SAT_W-1:0];
    end
  endfunction

  function automatic logic sat_ovf(input logic [SAT_W-1:0] a,
                                   input logic [SAT_W-1:0] b,
                                   input int unsigned      w);
    logic [SAT_W:0] full;
    full = {1'b0, a} + {1'b0, b};
    return (full > sat_max(w));
  endfunction

endpackage

// File: rtl/xnor_popcount_tree.sv
// XNOR + pipelined popcount tree with valid/last/threshold sidebands.
//   clk, rstn   : clock, synchronous active-low reset
//   ce          : advance every stage (pipeline frozen when low)
//   in_valid    : beat present on xi/wi
//   in_last     : beat closes a vector (ignored unless in_valid)
//   xi, wi      : N-bit activation / weight words
//   ti          : threshold travelling alongside the beat
//   out_valid   : pc/out_last/out_ti describe a beat
//   out_last    : that beat closes its vector
//   out_ti      : threshold that entered with the beat
//   out_pc      : number of matching bits, 0..N
// The $clog2(N) adder levels are split evenly over PC_LAT register stages;
// a register sits after level k whenever floor(k*PC_LAT/levels) steps up.
module xnor_popcount_tree
  import bnn_pkg::*;
#(
  parameter int N      = 128,
  parameter int PC_LAT = 2,
  parameter int TI_W   = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [N-1:0]         xi,
  input  logic [N-1:0]         wi,
  input  logic [TI_W-1:0]      ti,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [TI_W-1:0]      out_ti,
  output logic [pc_w(N)-1:0]   out_pc
);

  localparam int PCW  = pc_w(N);
  localparam int LVLS = $clog2(N);

  logic [N-1:0] y_s;
  assign y_s = ~(xi ^ wi);

  for (genvar k = 0; k <= LVLS; k++) begin : g_lvl
    logic [PCW-1:0] node_s [N >> k];
    logic [PCW-1:0] fwd_s  [N >> k];

    if (k == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign node_s[i] = {{(PCW-1){1'b0}}, y_s[i]};
      end
    end else begin : g_add
      for (genvar i = 0; i < (N >> k); i++) begin : g_pair
        assign node_s[i] = g_lvl[k-1].fwd_s[2*i] + g_lvl[k-1].fwd_s[2*i+1];
      end
    end

    if ((k > 0) && (((k * PC_LAT) / LVLS) != (((k - 1) * PC_LAT) / LVLS))) begin : g_reg
      logic [PCW-1:0] fwd_d [N >> k];
      logic [PCW-1:0] fwd_q [N >> k];

      // Next value of this level's pipeline register: load when enabled, else hold.
      always_comb begin
        for (int i = 0; i < (N >> k); i++) begin
          if (ce) begin
            fwd_d[i] = node_s[i];
          end else begin
            fwd_d[i] = fwd_q[i];
          end
        end
      end

      // Level pipeline register (data only; qualified by the valid sideband).
      always_ff @(posedge clk) begin
        fwd_q <= fwd_d;
      end

      assign fwd_s = fwd_q;
    end else begin : g_pass
      assign fwd_s = node_s;
    end
  end

  assign out_pc = g_lvl[LVLS].fwd_s[0];

  // Sideband shift register, one slot per tree register stage.
  logic [PC_LAT-1:0] vld_d, vld_q;
  logic [PC_LAT-1:0] last_d, last_q;
  logic [TI_W-1:0]   ti_d [PC_LAT];
  logic [TI_W-1:0]   ti_q [PC_LAT];

  // Next sideband state: shift on ce, otherwise hold.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    ti_d   = ti_q;
    if (ce) begin
      vld_d[0]  = in_valid;
      last_d[0] = in_valid & in_last;
      ti_d[0]   = ti;
      for (int s = 1; s < PC_LAT; s++) begin
        vld_d[s]  = vld_q[s-1];
        last_d[s] = last_q[s-1];
        ti_d[s]   = ti_q[s-1];
      end
    end else begin
      vld_d  = vld_q;
      last_d = last_q;
      ti_d   = ti_q;
    end
  end

  // Sideband registers; reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int s = 0; s < PC_LAT; s++) begin
        ti_q[s] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      ti_q   <= ti_d;
    end
  end

  assign out_valid = vld_q[PC_LAT-1];
  assign out_last  = last_q[PC_LAT-1];
  assign out_ti    = ti_q[PC_LAT-1];

endmodule

// File: rtl/xnor_popcount_neuron.sv
// Streaming binarised neuron: XNOR-popcount per beat, saturating accumulation
// until in_last, then sum / threshold bit / overflow flag on the output side.
//   clk, rstn            : clock, synchronous active-low reset
//   in_valid/in_ready    : beat handshake (in_ready has no in_valid path)
//   in_last              : final beat of the vector
//   xi, wi               : N-bit activation / weight words
//   ti                   : threshold, used only from the accepted last beat
//   out_valid/out_ready  : result handshake, result held until accepted
//   out_sum              : saturated popcount sum of the vector
//   out_bit              : out_sum > threshold (unsigned, strict)
//   out_ovf              : accumulator clamped somewhere in this vector
// One global enable freezes the whole pipe while a result waits, so nothing
// is lost or duplicated under backpressure.
module xnor_popcount_neuron
  import bnn_pkg::*;
#(
  parameter int N      = 128,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int PC_LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [N-1:0]     xi,
  input  logic [N-1:0]     wi,
  input  logic [ACC_W-1:0] ti,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_bit,
  output logic             out_ovf
);

  localparam int PCW = pc_w(N);

  logic             en_s;
  logic             pc_valid_s;
  logic             pc_last_s;
  logic [ACC_W-1:0] pc_ti_s;
  logic [PCW-1:0]   pc_s;
  logic [ACC_W-1:0] sum_s;
  logic             ovf_s;

  logic [ACC_W-1:0] acc_d, acc_q;
  logic             ovf_acc_d, ovf_acc_q;
  logic             out_valid_d, out_valid_q;
  logic [ACC_W-1:0] out_sum_d, out_sum_q;
  logic             out_bit_d, out_bit_q;
  logic             out_ovf_d, out_ovf_q;

  assign en_s     = ~out_valid_q | out_ready;
  assign in_ready = en_s;

  xnor_popcount_tree #(
    .N      (N),
    .PC_LAT (PC_LAT),
    .TI_W   (ACC_W)
  ) u_tree (
    .clk       (clk),
    .rstn      (rstn),
    .ce        (en_s),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .xi        (xi),
    .wi        (wi),
    .ti        (ti),
    .out_valid (pc_valid_s),
    .out_last  (pc_last_s),
    .out_ti    (pc_ti_s),
    .out_pc    (pc_s)
  );

  // Saturating running sum including the beat leaving the tree.
  always_comb begin
    sum_s = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(pc_s), ACC_W));
    ovf_s = sat_ovf(SAT_W'(acc_q), SAT_W'(pc_s), ACC_W);
  end

  // Accumulator and result register next-state.
  always_comb begin
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    out_sum_d = out_sum_q;
    out_bit_d = out_bit_q;
    out_ovf_d = out_ovf_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (en_s && pc_valid_s) begin
      if (pc_last_s) begin
        // Close the vector and clear the accumulator in the same cycle so
        // the next vector's first beat can land right behind it.
        out_sum_d   = sum_s;
        out_ovf_d   = ovf_acc_q | ovf_s;
        out_bit_d   = (sum_s > pc_ti_s);
        out_valid_d = 1'b1;
        acc_d       = '0;
        ovf_acc_d   = 1'b0;
      end else begin
        acc_d     = sum_s;
        ovf_acc_d = ovf_acc_q | ovf_s;
      end
    end else begin
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
    end
  end

  // Accumulator and output registers; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_bit_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_bit_q   <= out_bit_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_bit   = out_bit_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_xnor_popcount_neuron.sv
// Directed bench for xnor_popcount_neuron (N=128, PC_LAT=2). A second
// instance with ACC_W=8 shares the input stream to exercise saturation.
module tb_xnor_popcount_neuron;

  localparam int N      = 128;
  localparam int PC_LAT = 2;

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_valid;
  logic           in_ready;
  logic           in_ready8;
  logic           in_last;
  logic [N-1:0]   xi;
  logic [N-1:0]   wi;
  logic [15:0]    ti;
  logic           out_valid, out_valid8;
  logic           out_ready;
  logic [15:0]    out_sum;
  logic [7:0]     out_sum8;
  logic           out_bit, out_bit8;
  logic           out_ovf, out_ovf8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  typedef struct {
    int   sum;
    logic b;
    logic ovf;
    int   cyc;
  } res_t;

  res_t rq[$];
  res_t rq8[$];

  logic [N-1:0] ones;
  logic [N-1:0] zero;
  logic [N-1:0] pat;
  logic [N-1:0] half;
  logic [N-1:0] low4;

  xnor_popcount_neuron #(.N(N), .ACC_W(16), .PC_LAT(PC_LAT)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .xi(xi), .wi(wi), .ti(ti),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_bit(out_bit), .out_ovf(out_ovf)
  );

  xnor_popcount_neuron #(.N(N), .ACC_W(8), .PC_LAT(PC_LAT)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready8),
    .in_last(in_last), .xi(xi), .wi(wi), .ti(ti[7:0]),
    .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
    .out_bit(out_bit8), .out_ovf(out_ovf8)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency and spacing checks.
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitors: record every accepted result mid-cycle.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      rq.push_back('{sum: int'(out_sum), b: out_bit, ovf: out_ovf, cyc: cyc});
    end
    if (rstn && out_valid8 && out_ready) begin
      rq8.push_back('{sum: int'(out_sum8), b: out_bit8, ovf: out_ovf8, cyc: cyc});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] w,
                      input logic l, input logic [15:0] t);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    xi       = x;
    wi       = w;
    in_last  = l;
    ti       = t;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) sync();
  endtask

  task automatic take(input string tag, input bit use8, input int esum,
                      input logic ebit, input logic eovf, output int rcyc);
    res_t r;
    int guard;
    guard = 0;
    rcyc  = 0;
    while (((use8 ? rq8.size() : rq.size()) == 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if ((use8 ? rq8.size() : rq.size()) == 0) begin
      chk({tag, "_timeout"}, 32'(rq.size()), 32'd1);
    end else begin
      if (use8) r = rq8.pop_front();
      else      r = rq.pop_front();
      chk({tag, "_sum"}, 32'(r.sum), 32'(esum));
      chk({tag, "_bit"}, 32'(r.b), 32'(ebit));
      chk({tag, "_ovf"}, 32'(r.ovf), 32'(eovf));
      rcyc = r.cyc;
    end
  endtask

  initial begin
    int c0, c1, vcount;
    ones = '1;
    zero = '0;
    pat  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    half = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    low4 = 128'hF;
    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    xi = '0; wi = '0; ti = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_bit",   32'(out_bit),   32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);

    // Single beat, all match, with latency
    sync();
    send(ones, ones, 1'b1, 16'd100);
    idle(0);
    take("single", 1'b0, 128, 1'b1, 1'b0, c0);
    chk("single_latency", 32'(c0 - acc_cyc), 32'(PC_LAT));

    // 4-beat vector with a mid-vector bubble; ti on non-last beats ignored
    sync();
    send(ones, zero, 1'b0, 16'd0);
    send(pat, pat, 1'b0, 16'd1);
    idle(3);
    send(ones, ones, 1'b0, 16'd2);
    send(zero, zero, 1'b1, 16'd384);
    idle(0);
    take("four_t384", 1'b0, 384, 1'b0, 1'b0, c0);
    sync();
    send(ones, zero, 1'b0, 16'd999);
    send(pat, pat, 1'b0, 16'd0);
    send(ones, ones, 1'b0, 16'd0);
    send(zero, zero, 1'b1, 16'd383);
    idle(0);
    take("four_t383", 1'b0, 384, 1'b1, 1'b0, c0);

    // Partial match, equality with threshold is not above it
    sync();
    send(low4, zero, 1'b1, 16'd124);
    idle(0);
    take("partial", 1'b0, 124, 1'b0, 1'b0, c0);

    // Back-to-back 2-beat vectors
    sync();
    send(ones, ones, 1'b0, 16'd0);
    send(pat, pat, 1'b1, 16'd255);
    send(zero, zero, 1'b0, 16'd0);
    send(ones, zero, 1'b1, 16'd128);
    idle(0);
    take("b2b_a", 1'b0, 256, 1'b1, 1'b0, c0);
    take("b2b_b", 1'b0, 128, 1'b0, 1'b0, c1);
    chk("b2b_spacing", 32'(c1 - c0), 32'd2);

    // Backpressure while three vectors stream
    sync();
    out_ready = 1'b0;
    fork
      begin
        send(ones, ones, 1'b1, 16'd200);
        send(pat, pat, 1'b0, 16'd0);
        send(half, zero, 1'b1, 16'd191);
        send(ones, zero, 1'b1, 16'd0);
        idle(0);
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low",   32'(in_ready),  32'd0);
        chk("bp_out_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    take("bp_v1", 1'b0, 128, 1'b0, 1'b0, c0);
    take("bp_v2", 1'b0, 192, 1'b1, 1'b0, c0);
    take("bp_v3", 1'b0, 0,   1'b0, 1'b0, c0);

    // Saturation on the 8-bit instance
    sync();
    rq.delete();
    rq8.delete();
    send(ones, ones, 1'b0, 16'd0);
    send(pat, pat, 1'b0, 16'd0);
    send(zero, zero, 1'b1, 16'd200);
    send(ones, ones, 1'b1, 16'd200);
    idle(0);
    take("sat8_v1",  1'b1, 255, 1'b1, 1'b1, c0);
    take("sat8_v2",  1'b1, 128, 1'b0, 1'b0, c0);
    take("sat16_v1", 1'b0, 384, 1'b1, 1'b0, c0);
    take("sat16_v2", 1'b0, 128, 1'b0, 1'b0, c0);

    // Reset in the middle of a vector
    sync();
    send(ones, ones, 1'b0, 16'd0);
    send(ones, ones, 1'b0, 16'd0);
    idle(4);
    rq.delete();
    rstn = 1'b0;
    sync();
    rstn = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    chk("rstmid_valid_cycles", 32'(vcount), 32'd0);
    chk("rstmid_no_result",    32'(rq.size()), 32'd0);
    sync();
    send(zero, zero, 1'b1, 16'd127);
    idle(0);
    take("rstmid_next", 1'b0, 128, 1'b1, 1'b0, c0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
